// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Shares a single data memory between two requesters:
//   port A - CPU load/store stage
//   port B - DMA / debug loader
//
// A three-state FSM (IDLE, SERVE_A, SERVE_B) decides which port drives the
// memory. While a port is served, its request passes straight through to the
// memory in the same cycle. A port may hold ownership for at most MAX_BURST
// consecutive beats while the other port is waiting. Read data is captured
// into a per-port register and flagged with a one-cycle valid pulse.
//
// Optional build macro:
//   DMEM_ARB_ROUND_ROBIN_EN - when defined, a one-bit last-owner register
//   (reset to B) breaks IDLE ties in favour of the port that was not served
//   last. When undefined, A always wins an IDLE tie and the register does
//   not exist.
//
// Ports:
//   clk, reset                  clock (rising edge) / async active-low reset
//   aReq, aWrite                A beat request, 1 = write / 0 = read
//   aAddress, aWriteData        A word address and write data
//   aGrant                      A beat accepted this cycle
//   aReadData, aValid           registered A read data, one-cycle valid
//   bReq ... bValid             same set for port B
//   memAddress, memWriteData    to memory address / write data
//   memEnableRead/Write         to memory enables
//   memReadData                 from memory (combinational read)
//   owner                       00 none, 01 A, 10 B
// -----------------------------------------------------------------------------

module data_memory_arbiter #(
    parameter int BITS      = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            aReq,
    input  logic            aWrite,
    input  logic [BITS-1:0] aAddress,
    input  logic [BITS-1:0] aWriteData,
    output logic            aGrant,
    output logic [BITS-1:0] aReadData,
    output logic            aValid,

    input  logic            bReq,
    input  logic            bWrite,
    input  logic [BITS-1:0] bAddress,
    input  logic [BITS-1:0] bWriteData,
    output logic            bGrant,
    output logic [BITS-1:0] bReadData,
    output logic            bValid,

    output logic [BITS-1:0] memAddress,
    output logic [BITS-1:0] memWriteData,
    output logic            memEnableRead,
    output logic            memEnableWrite,
    input  logic [BITS-1:0] memReadData,

    output logic [1:0]      owner
);

    // state | meaning
    // IDLE    | nobody owns the memory; arbitrate next edge
    // SERVE_A | port A drives the memory
    // SERVE_B | port B drives the memory
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SERVE_A = 2'b01,
        ST_SERVE_B = 2'b10
    } state_e;

    // MAX_BURST is limited to 1..255, so an 8-bit beat counter suffices.
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    state_e          state_q, state_d;
    logic [7:0]      count_q, count_d;
    logic            a_valid_q, a_valid_d;
    logic            b_valid_q, b_valid_d;
    logic [BITS-1:0] a_read_data_q, a_read_data_d;
    logic [BITS-1:0] b_read_data_q, b_read_data_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // 0 = A was served last, 1 = B was served last.
    logic            last_owner_b_q, last_owner_b_d;
`endif

    logic            serve_a;
    logic            serve_b;
    logic            cur_req;
    logic            oth_req;
    logic            beat;
    logic [7:0]      count_inc;
    logic            burst_done;
    logic            a_read_beat;
    logic            b_read_beat;

    // -------------------------------------------------------------------------
    // Memory-side mux and grants (combinational from the registered state)
    // -------------------------------------------------------------------------
    always_comb begin
        serve_a = (state_q == ST_SERVE_A);
        serve_b = (state_q == ST_SERVE_B);

        aGrant  = serve_a & aReq;
        bGrant  = serve_b & bReq;

        memAddress     = '0;
        memWriteData   = '0;
        memEnableRead  = 1'b0;
        memEnableWrite = 1'b0;
        if (serve_a) begin
            memAddress     = aAddress;
            memWriteData   = aWriteData;
            memEnableRead  = aReq & ~aWrite;
            memEnableWrite = aReq & aWrite;
        end else if (serve_b) begin
            memAddress     = bAddress;
            memWriteData   = bWriteData;
            memEnableRead  = bReq & ~bWrite;
            memEnableWrite = bReq & bWrite;
        end

        a_read_beat = aGrant & ~aWrite;
        b_read_beat = bGrant & ~bWrite;
    end

    // -------------------------------------------------------------------------
    // Next-state and burst accounting
    // -------------------------------------------------------------------------
    always_comb begin
        cur_req    = serve_a ? aReq : bReq;
        oth_req    = serve_a ? bReq : aReq;
        beat       = (serve_a | serve_b) & cur_req;
        count_inc  = count_q + 8'd1;
        // The beat taking place this cycle is the one that reaches the limit.
        burst_done = beat & (count_inc == MAX_BURST_C);

        state_d = state_q;
        count_d = count_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_owner_b_d = last_owner_b_q;
`endif

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (aReq && bReq) begin
                    state_d = last_owner_b_q ? ST_SERVE_A : ST_SERVE_B;
                end else if (aReq) begin
                    state_d = ST_SERVE_A;
                end else if (bReq) begin
                    state_d = ST_SERVE_B;
                end
`else
                if (aReq) begin
                    state_d = ST_SERVE_A;
                end else if (bReq) begin
                    state_d = ST_SERVE_B;
                end
`endif
            end

            ST_SERVE_A, ST_SERVE_B: begin
                if (oth_req && (!cur_req || burst_done)) begin
                    // Hand over directly, no IDLE bubble.
                    state_d = serve_a ? ST_SERVE_B : ST_SERVE_A;
                    count_d = '0;
                end else if (!cur_req) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (burst_done) begin
                    // Other port idle: keep ownership, start a fresh burst.
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if ((state_d != state_q) && (state_d != ST_IDLE)) begin
            last_owner_b_d = (state_d == ST_SERVE_B);
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Read-data capture: data registers hold until the port's next read beat
    // -------------------------------------------------------------------------
    always_comb begin
        a_valid_d     = a_read_beat;
        b_valid_d     = b_read_beat;
        a_read_data_d = a_read_beat ? memReadData : a_read_data_q;
        b_read_data_d = b_read_beat ? memReadData : b_read_data_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            a_valid_q      <= 1'b0;
            b_valid_q      <= 1'b0;
            a_read_data_q  <= '0;
            b_read_data_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_owner_b_q <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            a_valid_q      <= a_valid_d;
            b_valid_q      <= b_valid_d;
            a_read_data_q  <= a_read_data_d;
            b_read_data_q  <= b_read_data_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_owner_b_q <= last_owner_b_d;
`endif
        end
    end

    assign aValid    = a_valid_q;
    assign bValid    = b_valid_q;
    assign aReadData = a_read_data_q;
    assign bReadData = b_read_data_q;
    assign owner     = state_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for data_memory_arbiter: a directed vector table, hand-written
// multi-cycle sequences (burst fairness, tie-break, reset mid-burst, idle)
// and a random phase checked against a transaction-level reference model.
// -----------------------------------------------------------------------------

module tb_data_memory_arbiter;

    localparam int BITS      = 32;
    localparam int MAX_BURST = 4;
    localparam int MEM_WORDS = 64;

    logic            clk;
    logic            rst_n;
    logic            a_req, a_wr, b_req, b_wr;
    logic [BITS-1:0] a_addr, a_wd, b_addr, b_wd;
    logic            a_gnt, b_gnt, a_vld, b_vld;
    logic [BITS-1:0] a_rd, b_rd;
    logic [BITS-1:0] mem_addr, mem_wdata, mem_rdata;
    logic            mem_ren, mem_wen;
    logic [1:0]      owner;

    int tests = 0;
    int fails = 0;

    data_memory_arbiter #(.BITS(BITS), .MAX_BURST(MAX_BURST)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .aReq           (a_req),
        .aWrite         (a_wr),
        .aAddress       (a_addr),
        .aWriteData     (a_wd),
        .aGrant         (a_gnt),
        .aReadData      (a_rd),
        .aValid         (a_vld),
        .bReq           (b_req),
        .bWrite         (b_wr),
        .bAddress       (b_addr),
        .bWriteData     (b_wd),
        .bGrant         (b_gnt),
        .bReadData      (b_rd),
        .bValid         (b_vld),
        .memAddress     (mem_addr),
        .memWriteData   (mem_wdata),
        .memEnableRead  (mem_ren),
        .memEnableWrite (mem_wen),
        .memReadData    (mem_rdata),
        .owner          (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model (combinational read, write on edge) -------
    function automatic logic [31:0] mem_init(int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'hA5000000 + 32'(i * 17);
    endfunction

    logic [31:0] mem [MEM_WORDS];
    assign mem_rdata = mem[mem_addr[5:0]];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = mem_init(i);
        forever begin
            @(posedge clk);
            if (mem_wen) mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    // ---------------- checking helper ----------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------------------------
    typedef struct {
        int a_req; int a_wr; int a_addr; int a_wd;
        int b_req; int b_wr; int b_addr; int b_wd;
        int e_ag;  int e_bg; int e_own;
        int e_ren; int e_wen; int e_maddr;
        int e_av;  int e_bv; int e_ard; int e_brd;
    } vec_t;

    vec_t tbl [8];

    // ---------------- reference model state -----------------------------------
    logic [31:0] exp_mem [MEM_WORDS];
    int          m_own;      // 0 none, 1 A, 2 B
    int          m_beats;    // beats taken in the current turn
    int          m_last;     // port served most recently (round-robin tie-break)
    logic        m_av, m_bv;
    logic [31:0] m_ard, m_brd;

    logic        exp_fa_ag [15] = '{0,1,1,1,1,0,0,0,1,1,1,1,1,1,0};
    logic        exp_fa_bg [15] = '{0,0,0,0,0,1,1,0,0,0,0,0,0,0,0};
    int          exp_fa_ow [15] = '{0,1,1,1,1,2,2,2,1,1,1,1,1,1,1};

    initial begin
        int e_ag, e_bg, e_ren, e_wen, hold_a, hold_b, winner, mine, theirs, n;
        logic [31:0] e_addr, e_wd;

        rst_n  = 1'b0;
        a_req  = 1'b0; a_wr = 1'b0; a_addr = '0; a_wd = '0;
        b_req  = 1'b0; b_wr = 1'b0; b_addr = '0; b_wd = '0;

        tbl[0] = '{1,0,5,0, 0,0,0,0,           0,0,0, 0,0,0, 0,0,0,0};
        tbl[1] = '{1,0,5,0, 0,0,0,0,           1,0,1, 1,0,5, 0,0,0,0};
        tbl[2] = '{0,0,5,0, 0,0,0,0,           0,0,1, 0,0,5, 1,0,32'hDEADBEEF,0};
        tbl[3] = '{0,0,5,0, 1,1,9,32'h12345678, 0,0,0, 0,0,0, 0,0,32'hDEADBEEF,0};
        tbl[4] = '{0,0,5,0, 1,1,9,32'h12345678, 0,1,2, 0,1,9, 0,0,32'hDEADBEEF,0};
        tbl[5] = '{0,0,5,0, 1,0,9,32'h12345678, 0,1,2, 1,0,9, 0,0,32'hDEADBEEF,0};
        tbl[6] = '{0,0,5,0, 0,0,9,32'h12345678, 0,0,2, 0,0,9, 0,1,32'hDEADBEEF,32'h12345678};
        tbl[7] = '{0,0,0,0, 0,0,0,0,           0,0,0, 0,0,0, 0,0,32'hDEADBEEF,32'h12345678};

        for (int i = 0; i < MEM_WORDS; i++) exp_mem[i] = mem_init(i);

        // ---------------- reset state -------------------------------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_a_valid", 32'(a_vld), 0);
        chk("rst_b_valid", 32'(b_vld), 0);
        chk("rst_a_rdata", a_rd, 0);
        chk("rst_b_rdata", b_rd, 0);
        chk("rst_ren", 32'(mem_ren), 0);
        rst_n = 1'b1;
        next_cycle();

        // ---------------- table: single read, B write then read-back ------
        for (int i = 0; i < 8; i++) begin
            a_req  = (tbl[i].a_req != 0);
            a_wr   = (tbl[i].a_wr != 0);
            a_addr = tbl[i].a_addr;
            a_wd   = tbl[i].a_wd;
            b_req  = (tbl[i].b_req != 0);
            b_wr   = (tbl[i].b_wr != 0);
            b_addr = tbl[i].b_addr;
            b_wd   = tbl[i].b_wd;
            @(negedge clk);
            chk($sformatf("tbl%0d_a_grant", i), 32'(a_gnt), tbl[i].e_ag);
            chk($sformatf("tbl%0d_b_grant", i), 32'(b_gnt), tbl[i].e_bg);
            chk($sformatf("tbl%0d_owner", i), 32'(owner), tbl[i].e_own);
            chk($sformatf("tbl%0d_ren", i), 32'(mem_ren), tbl[i].e_ren);
            chk($sformatf("tbl%0d_wen", i), 32'(mem_wen), tbl[i].e_wen);
            chk($sformatf("tbl%0d_maddr", i), mem_addr, tbl[i].e_maddr);
            chk($sformatf("tbl%0d_a_valid", i), 32'(a_vld), tbl[i].e_av);
            chk($sformatf("tbl%0d_b_valid", i), 32'(b_vld), tbl[i].e_bv);
            chk($sformatf("tbl%0d_a_rdata", i), a_rd, tbl[i].e_ard);
            chk($sformatf("tbl%0d_b_rdata", i), b_rd, tbl[i].e_brd);
            if (tbl[i].e_wen != 0) chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].b_wd);
            next_cycle();
        end
        exp_mem[9] = 32'h12345678;

        // ---------------- burst fairness -----------------------------------
        for (int c = 0; c < 15; c++) begin
            a_req = (c <= 13); a_wr = 1'b0; a_addr = 2;
            b_req = (c >= 2 && c <= 6); b_wr = 1'b0; b_addr = 3;
            @(negedge clk);
            chk($sformatf("fair%0d_a_grant", c), 32'(a_gnt), 32'(exp_fa_ag[c]));
            chk($sformatf("fair%0d_b_grant", c), 32'(b_gnt), 32'(exp_fa_bg[c]));
            chk($sformatf("fair%0d_owner", c), 32'(owner), exp_fa_ow[c]);
            next_cycle();
        end
        a_req = 1'b0; b_req = 1'b0;
        next_cycle();

        // ---------------- reset during A's third read beat -----------------
        a_req = 1'b1; a_wr = 1'b0; a_addr = 7;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rmid%0d_a_grant", c), 32'(a_gnt), (c == 0) ? 0 : 1);
            if (c < 3) next_cycle();
        end
        chk("rmid_a_valid_pre", 32'(a_vld), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_a_grant", 32'(a_gnt), 0);
        chk("rmid_b_grant", 32'(b_gnt), 0);
        chk("rmid_ren", 32'(mem_ren), 0);
        chk("rmid_wen", 32'(mem_wen), 0);
        chk("rmid_owner", 32'(owner), 0);
        chk("rmid_a_valid", 32'(a_vld), 0);
        chk("rmid_b_valid", 32'(b_vld), 0);
        chk("rmid_a_rdata", a_rd, 0);
        chk("rmid_b_rdata", b_rd, 0);
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        chk("rmid_held_owner", 32'(owner), 0);
        rst_n = 1'b1;
        next_cycle();

        // ---------------- simultaneous requests from IDLE ------------------
        a_req = 1'b1; b_req = 1'b1; a_wr = 1'b0; b_wr = 1'b0; a_addr = 1; b_addr = 2;
        @(negedge clk);
        chk("tie1_idle_owner", 32'(owner), 0);
        next_cycle();
        @(negedge clk);
        chk("tie1_owner", 32'(owner), 1);
        chk("tie1_a_grant", 32'(a_gnt), 1);
        chk("tie1_b_grant", 32'(b_gnt), 0);
        next_cycle();
        a_req = 1'b0; b_req = 1'b0;
        next_cycle();
        a_req = 1'b1; b_req = 1'b1;
        @(negedge clk);
        chk("tie2_idle_owner", 32'(owner), 0);
        next_cycle();
        @(negedge clk);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        chk("tie2_owner", 32'(owner), 2);
        chk("tie2_b_grant", 32'(b_gnt), 1);
`else
        chk("tie2_owner", 32'(owner), 1);
        chk("tie2_a_grant", 32'(a_gnt), 1);
`endif
        next_cycle();
        a_req = 1'b0; b_req = 1'b0;
        next_cycle();

        // ---------------- idle quiet ---------------------------------------
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("quiet%0d", c),
                {27'd0, mem_ren, mem_wen, owner, (a_vld | b_vld)}, 0);
            next_cycle();
        end

        // ---------------- random phase vs reference model -----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_own = 0; m_beats = 0; m_last = 2;
        m_av = 1'b0; m_bv = 1'b0; m_ard = '0; m_brd = '0;
        hold_a = 0; hold_b = 0;
        next_cycle();

        for (int cyc = 0; cyc < 600; cyc++) begin
            if (hold_a == 0) begin
                a_req  = ($urandom_range(0, 9) < 6);
                a_wr   = 1'($urandom_range(0, 1));
                a_addr = $urandom_range(0, 15);
                a_wd   = $urandom;
            end
            if (hold_b == 0) begin
                b_req  = ($urandom_range(0, 9) < 5);
                b_wr   = 1'($urandom_range(0, 1));
                b_addr = $urandom_range(0, 15);
                b_wd   = $urandom;
            end
            @(negedge clk);

            e_ag   = (m_own == 1 && a_req) ? 1 : 0;
            e_bg   = (m_own == 2 && b_req) ? 1 : 0;
            e_ren  = ((e_ag == 1 && !a_wr) || (e_bg == 1 && !b_wr)) ? 1 : 0;
            e_wen  = ((e_ag == 1 && a_wr) || (e_bg == 1 && b_wr)) ? 1 : 0;
            e_addr = (m_own == 1) ? a_addr : (m_own == 2) ? b_addr : 32'd0;
            e_wd   = (m_own == 1) ? a_wd : (m_own == 2) ? b_wd : 32'd0;

            chk($sformatf("rnd%0d_a_grant", cyc), 32'(a_gnt), e_ag);
            chk($sformatf("rnd%0d_b_grant", cyc), 32'(b_gnt), e_bg);
            chk($sformatf("rnd%0d_owner", cyc), 32'(owner), m_own);
            chk($sformatf("rnd%0d_ren", cyc), 32'(mem_ren), e_ren);
            chk($sformatf("rnd%0d_wen", cyc), 32'(mem_wen), e_wen);
            chk($sformatf("rnd%0d_maddr", cyc), mem_addr, e_addr);
            chk($sformatf("rnd%0d_wdata", cyc), mem_wdata, e_wd);
            chk($sformatf("rnd%0d_a_valid", cyc), 32'(a_vld), 32'(m_av));
            chk($sformatf("rnd%0d_b_valid", cyc), 32'(b_vld), 32'(m_bv));
            chk($sformatf("rnd%0d_a_rdata", cyc), a_rd, m_ard);
            chk($sformatf("rnd%0d_b_rdata", cyc), b_rd, m_brd);

            // Effects of the coming clock edge.
            m_av = (e_ag == 1) && !a_wr;
            m_bv = (e_bg == 1) && !b_wr;
            if (m_av) m_ard = exp_mem[a_addr[5:0]];
            if (m_bv) m_brd = exp_mem[b_addr[5:0]];
            if (e_ag == 1 && a_wr) exp_mem[a_addr[5:0]] = a_wd;
            if (e_bg == 1 && b_wr) exp_mem[b_addr[5:0]] = b_wd;

            if (m_own == 0) begin
                winner = 0;
                if (a_req && b_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    winner = (m_last == 1) ? 2 : 1;
`else
                    winner = 1;
`endif
                end else if (a_req) begin
                    winner = 1;
                end else if (b_req) begin
                    winner = 2;
                end
                m_own   = winner;
                m_beats = 0;
                if (winner != 0) m_last = winner;
            end else begin
                mine   = (m_own == 1) ? int'(a_req) : int'(b_req);
                theirs = (m_own == 1) ? int'(b_req) : int'(a_req);
                n      = m_beats + mine;
                if (theirs == 1 && (mine == 0 || n == MAX_BURST)) begin
                    m_own   = 3 - m_own;
                    m_beats = 0;
                    m_last  = m_own;
                end else if (mine == 0) begin
                    m_own   = 0;
                    m_beats = 0;
                end else begin
                    m_beats = (n == MAX_BURST) ? 0 : n;
                end
            end

            // A requester keeps its request until it is granted.
            hold_a = (a_req && e_ag == 0) ? 1 : 0;
            hold_b = (b_req && e_bg == 0) ? 1 : 0;
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares one DataMemoryUnit between two requesters: port A (CPU load/store stage) and port B (DMA/debug loader).
- Sequences memory access through a 3-state FSM with bounded bursts.
- Drives the memory's address, writeData, enableRead and enableWrite.
- Returns registered read data to the owning requester.

Parameters:
BITS, 32, data/address width; matches the memory's BITS
MAX_BURST, 4, maximum consecutive beats one requester keeps ownership while the other waits; legal range 1..255

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
aReq  input  1  A requests a beat; held high until aGrant
aWrite  input  1  A beat is a write (1) or read (0)
aAddress  input  BITS  A word address
aWriteData  input  BITS  A write data
aGrant  output  1  A beat accepted this cycle
aReadData  output  BITS  registered read data for A
aValid  output  1  aReadData valid; one-cycle pulse
bReq, bWrite, bAddress, bWriteData, bGrant, bReadData, bValid  same as A, for port B
memAddress  output  BITS  to memory address
memWriteData  output  BITS  to memory writeData
memEnableRead  output  1  to memory enableRead
memEnableWrite  output  1  to memory enableWrite
memReadData  input  BITS  from memory readData (combinational)
owner  output  2  00 none, 01 A, 10 B (debug)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, burst count=0, aValid=bValid=0, aReadData=bReadData=0. Grants, memory enables and owner are deasserted as soon as reset goes low.
- States: IDLE, SERVE_A, SERVE_B.
- IDLE:
  - No grants; memEnableRead=memEnableWrite=0; memAddress=memWriteData=0.
  - Next state: SERVE_A if aReq, else SERVE_B if bReq, else IDLE.
  - Arbitration costs exactly 1 cycle from IDLE.
- SERVE_X:
  - Memory signals mux combinationally from port X.
  - xGrant = xReq.
  - memEnableWrite = xReq & xWrite; memEnableRead = xReq & ~xWrite.
  - The other port's grant stays 0.
- Beat: a cycle in SERVE_X with xReq=1.
  - Write commits at that clock edge.
  - Read: memReadData is captured into xReadData, and xValid=1 on the following cycle only.
  - xReadData holds its value until the next read beat of X.
  - Write beats do not pulse xValid.
- Burst counter: increments on each beat; cleared on any state change.
- Transitions out of SERVE_X, evaluated at each edge:
  - Other port requesting and (xReq=0 or the count reaches MAX_BURST with this beat) -> SERVE_Y, count=0, no IDLE bubble.
  - Else if xReq=0 -> IDLE.
  - Else if the count reaches MAX_BURST and the other port is idle -> stay, count=0.
  - Else stay.
- Fixed priority (macro absent): A wins only from IDLE when both request simultaneously. Fairness inside SERVE states comes from MAX_BURST.
- Requesters must keep write/address/data stable while xReq=1 and xGrant=0. The arbiter does not latch requests.
- Address range checking is left to the memory; out-of-range writes are silently dropped there.
- Reset mid-burst: the in-flight beat is lost and no xValid is generated. A write whose edge coincides with reset assertion has undefined commit.
- owner reflects the state: IDLE=00, SERVE_A=01, SERVE_B=10.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit lastOwner register (reset to B) replaces fixed priority. In IDLE with both requesting, the port not equal to lastOwner wins. lastOwner updates on every entry to a SERVE state.
- Undefined: fixed A-priority as above, and no lastOwner register exists.

Test Plan:
- Single read: preload mem[5]=0xDEADBEEF; aReq=1, aWrite=0, aAddress=5 from IDLE -> aGrant high in cycle 2; aValid=1 with aReadData=0xDEADBEEF in cycle 3; bGrant never high.
- Write then read back: B writes 0x12345678 to address 9, then reads address 9 -> bValid with 0x12345678; owner=10 throughout.
- Burst fairness (MAX_BURST=4): A holds aReq for 10 beats, bReq rises during A's 2nd beat -> A gets beats 1-4, B granted the next cycle with no IDLE, A resumes after B drops.
- Simultaneous request from IDLE: aReq=bReq=1 -> A served first. With DMEM_ARB_ROUND_ROBIN_EN after reset, A is also first; on the next tie, B is first.
- Reset mid-burst: assert reset low during A's 3rd read beat -> all grants, enables and valids 0 immediately; state IDLE; readData regs 0.
- Idle quiet: no requests for 20 cycles -> memEnableRead=memEnableWrite=0, owner=00, no valid pulses.
